// File: rtl/divisor_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/done handshake.
// Divide-by-zero short-circuits to DONE with Q all ones and R equal to the dividend.
module divisor_seq #(
  parameter int unsigned n = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  output logic [n-1:0] Q,
  output logic [n-1:0] R,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  localparam int unsigned CW = $clog2(n) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [n-1:0]  regq_q, regq_d;
  logic [n-1:0]  regr_q, regr_d;
  logic [n-1:0]  regd_q, regd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dz_q, dz_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [n:0]    sh;
  logic [n:0]    diff;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      regq_q  <= '0;
      regr_q  <= '0;
      regd_q  <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      regq_q  <= regq_d;
      regr_q  <= regr_d;
      regd_q  <= regd_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and shift/subtract step
  always_comb begin
    state_d = state_q;
    regq_d  = regq_q;
    regr_d  = regr_q;
    regd_d  = regd_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    sh      = {regr_q, regq_q[n-1]};
    diff    = sh - {1'b0, regd_q};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (B != '0) begin
            regq_d  = A;
            regd_d  = B;
            regr_d  = '0;
            cnt_d   = CW'(n);
            dz_d    = 1'b0;
            state_d = S_ITER;
          end else begin
            regq_d  = '1;
            regr_d  = A;
            dz_d    = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_ITER: begin
        // A clear borrow bit means the shifted remainder covers the divisor
        if (!diff[n]) begin
          regr_d = diff[n-1:0];
          regq_d = {regq_q[n-2:0], 1'b1};
        end else begin
          regr_d = sh[n-1:0];
          regq_d = {regq_q[n-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  assign Q           = regq_q;
  assign R           = regr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_divisor_seq.sv
// Directed vector table plus hand-written handshake, abort and sweep sequences for divisor_seq.
module tb_divisor_seq;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic [7:0] Q;
  logic [7:0] R;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int total;
  int bad;

  divisor_seq #(.n(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .A          (A),
    .B          (B),
    .Q          (Q),
    .R          (R),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called #1 after a rising edge; returns edges from acceptance until done is seen.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, output int lat);
    A     = a;
    B     = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A     = 8'($urandom);
    B     = 8'($urandom);
    chk("busy_after_accept", int'(busy), 1);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic step(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int lat;
    int pulses;
    int exp_lat;
    logic [7:0] a;
    logic [7:0] b;

    total = 0;
    bad   = 0;
    reset = 1'b1;
    start = 1'b0;
    A     = 8'd0;
    B     = 8'd0;

    vecs[0]  = '{a: 8'd100, b: 8'd7,   q: 8'd14,  r: 8'd2,  dz: 1'b0};
    vecs[1]  = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,  dz: 1'b0};
    vecs[2]  = '{a: 8'd5,   b: 8'd9,   q: 8'd0,   r: 8'd5,  dz: 1'b0};
    vecs[3]  = '{a: 8'd200, b: 8'd200, q: 8'd1,   r: 8'd0,  dz: 1'b0};
    vecs[4]  = '{a: 8'd42,  b: 8'd0,   q: 8'd255, r: 8'd42, dz: 1'b1};
    vecs[5]  = '{a: 8'd0,   b: 8'd5,   q: 8'd0,   r: 8'd0,  dz: 1'b0};
    vecs[6]  = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0,  dz: 1'b0};
    vecs[7]  = '{a: 8'd254, b: 8'd16,  q: 8'd15,  r: 8'd14, dz: 1'b0};
    vecs[8]  = '{a: 8'd1,   b: 8'd255, q: 8'd0,   r: 8'd1,  dz: 1'b0};
    vecs[9]  = '{a: 8'd0,   b: 8'd0,   q: 8'd255, r: 8'd0,  dz: 1'b1};
    vecs[10] = '{a: 8'd128, b: 8'd3,   q: 8'd42,  r: 8'd2,  dz: 1'b0};

    step(2);
    chk("reset_Q", int'(Q), 0);
    chk("reset_R", int'(R), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_dz", int'(div_by_zero), 0);
    reset = 1'b0;
    step(1);

    // Directed table
    for (int i = 0; i < 11; i++) begin
      exp_lat = vecs[i].dz ? 0 : 8;
      run_op(vecs[i].a, vecs[i].b, lat);
      chk($sformatf("v%0d_latency", i), lat, exp_lat);
      chk($sformatf("v%0d_Q", i), int'(Q), int'(vecs[i].q));
      chk($sformatf("v%0d_R", i), int'(R), int'(vecs[i].r));
      chk($sformatf("v%0d_dz", i), int'(div_by_zero), int'(vecs[i].dz));
      step(1);
      chk($sformatf("v%0d_done_pulse", i), int'(done), 0);
      chk($sformatf("v%0d_idle", i), int'(busy), 0);
      step(1);
      chk($sformatf("v%0d_Q_hold", i), int'(Q), int'(vecs[i].q));
      chk($sformatf("v%0d_R_hold", i), int'(R), int'(vecs[i].r));
      chk($sformatf("v%0d_dz_hold", i), int'(div_by_zero), int'(vecs[i].dz));
    end

    // Start held high through ITER and DONE must be ignored
    A     = 8'd100;
    B     = 8'd7;
    start = 1'b1;
    step(1);
    A      = 8'd9;
    B      = 8'd3;
    lat    = 0;
    pulses = 0;
    while (!done && lat < 40) begin
      step(1);
      lat++;
    end
    chk("busy_start_latency", lat, 8);
    chk("busy_start_Q", int'(Q), 14);
    chk("busy_start_R", int'(R), 2);
    step(1);
    start = 1'b0;
    chk("busy_start_done_low", int'(done), 0);
    chk("busy_start_idle", int'(busy), 0);
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (done) pulses++;
    end
    chk("busy_start_extra_pulses", pulses, 0);
    chk("busy_start_Q_hold", int'(Q), 14);
    chk("busy_start_R_hold", int'(R), 2);

    // Reset sampled on the 4th ITER edge aborts the division
    A     = 8'd100;
    B     = 8'd7;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(3);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_Q", int'(Q), 0);
    chk("abort_R", int'(R), 0);
    chk("abort_done", int'(done), 0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (done) pulses++;
    end
    chk("abort_no_done", pulses, 0);
    run_op(8'd77, 8'd6, lat);
    chk("after_abort_latency", lat, 8);
    chk("after_abort_Q", int'(Q), 12);
    chk("after_abort_R", int'(R), 5);
    step(1);

    // Coarse sweep against integer division
    for (int ai = 0; ai < 256; ai += 37) begin
      for (int bi = 0; bi < 256; bi += 23) begin
        a = 8'(ai);
        b = 8'(bi);
        run_op(a, b, lat);
        if (b == 8'd0) begin
          chk("sweep_latency", lat, 0);
          chk("sweep_Q", int'(Q), 255);
          chk("sweep_R", int'(R), ai);
          chk("sweep_dz", int'(div_by_zero), 1);
        end else begin
          chk("sweep_latency", lat, 8);
          chk("sweep_Q", int'(Q), ai / bi);
          chk("sweep_R", int'(R), ai % bi);
          chk("sweep_dz", int'(div_by_zero), 0);
        end
        step(1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
